// File: rtl/mult_seq_ctrl.sv
// Shift-add multiplier sequencer: drives A/Q register control codes.
// Define MULT_SEQ_CTRL_SKIP_ZERO_EN to fold zero-bit add cycles into a shift.
module mult_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             q0,
  output logic [1:0]       a_ctrl,
  output logic [1:0]       q_ctrl,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ADD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] C_LOAD  = 2'b00;
  localparam logic [1:0] C_RST   = 2'b01;
  localparam logic [1:0] C_SHIFT = 2'b10;
  localparam logic [1:0] C_HOLD  = 2'b11;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] iter_nx;
  logic             last;

  assign last = (iter_count == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      iter_count <= '0;
    end else begin
      state      <= state_nx;
      iter_count <= iter_nx;
    end
  end

  always_comb begin
    state_nx = state;
    iter_nx  = iter_count;
    unique case (state)
      IDLE: begin
        if (start) state_nx = INIT;
      end
      INIT: begin
        iter_nx  = '0;
        state_nx = ADD;
      end
      ADD: begin
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
        // zero bit: shift now and stay in ADD for the next bit
        if (!q0) begin
          iter_nx  = iter_count + ONE;
          state_nx = last ? DONE : ADD;
        end else begin
          state_nx = SHIFT;
        end
`else
        state_nx = SHIFT;
`endif
      end
      SHIFT: begin
        iter_nx  = iter_count + ONE;
        state_nx = last ? DONE : ADD;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // reset clears A on the same edge it returns the FSM to IDLE
  always_comb begin
    a_ctrl = C_HOLD;
    q_ctrl = C_HOLD;
    busy   = 1'b0;
    done   = 1'b0;
    if (reset) begin
      a_ctrl = C_RST;
    end else begin
      unique case (state)
        IDLE: begin
          a_ctrl = C_HOLD;
        end
        INIT: begin
          a_ctrl = C_RST;
          q_ctrl = C_LOAD;
          busy   = 1'b1;
        end
        ADD: begin
          busy = 1'b1;
          if (q0) begin
            a_ctrl = C_LOAD;
          end else begin
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
            a_ctrl = C_SHIFT;
            q_ctrl = C_SHIFT;
`else
            a_ctrl = C_HOLD;
`endif
          end
        end
        SHIFT: begin
          a_ctrl = C_SHIFT;
          q_ctrl = C_SHIFT;
          busy   = 1'b1;
        end
        DONE: begin
          done = 1'b1;
        end
        default: begin
          a_ctrl = C_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed vector table, hand sequences,
// and random operations against a per-operation trace model.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             q0;
  logic [1:0]       a_ctrl;
  logic [1:0]       q_ctrl;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_count;

  int errors = 0;
  int checks = 0;
  int iter_hold = 0;

  mult_seq_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .q0(q0),
    .a_ctrl(a_ctrl),
    .q_ctrl(q_ctrl),
    .busy(busy),
    .done(done),
    .iter_count(iter_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0]  m;
    int                len;
    logic [0:11][1:0]  seq;
    logic [15:0]       smask;
  } vec_t;

  typedef struct {
    logic       q0;
    logic [1:0] a;
    logic [1:0] q;
    logic       busy;
    logic       done;
    int         iter;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[4];

`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
  localparam int THIRD_ADD = 4;
  localparam bit SKIP = 1'b1;
`else
  localparam int THIRD_ADD = 6;
  localparam bit SKIP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Whole-operation trace derived from the multiplier bits.
  task automatic push_op(input logic [WIDTH-1:0] m);
    exp_t e;
    e.q0 = 1'($urandom_range(0, 1));
    e.a = 2'b01; e.q = 2'b00; e.busy = 1; e.done = 0;
    e.iter = iter_hold;
    exp_q.push_back(e);
    for (int i = 0; i < WIDTH; i++) begin
      e.busy = 1; e.done = 0; e.iter = i;
      if (m[i]) begin
        e.q0 = 1; e.a = 2'b00; e.q = 2'b11;
        exp_q.push_back(e);
        e.q0 = 1'($urandom_range(0, 1));
        e.a = 2'b10; e.q = 2'b10;
        exp_q.push_back(e);
      end else if (SKIP) begin
        e.q0 = 0; e.a = 2'b10; e.q = 2'b10;
        exp_q.push_back(e);
      end else begin
        e.q0 = 0; e.a = 2'b11; e.q = 2'b11;
        exp_q.push_back(e);
        e.q0 = 1'($urandom_range(0, 1));
        e.a = 2'b10; e.q = 2'b10;
        exp_q.push_back(e);
      end
    end
    e.q0 = 1'($urandom_range(0, 1));
    e.a = 2'b11; e.q = 2'b11; e.busy = 0; e.done = 1;
    e.iter = WIDTH;
    exp_q.push_back(e);
    iter_hold = WIDTH;
  endtask

  // mode 0: random start, 1: start held high, 2: start low
  task automatic run_model(input int n, input int mode);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      reset = 0;
      if (exp_q.size() == 0) begin
        if (mode == 1) start = 1;
        else if (mode == 2) start = 0;
        else start = ($urandom_range(0, 2) == 0);
        q0 = 1'($urandom_range(0, 1));
        e.a = 2'b11; e.q = 2'b11; e.busy = 0; e.done = 0;
        e.iter = iter_hold;
        if (start) push_op(WIDTH'($urandom));
      end else begin
        e = exp_q.pop_front();
        q0 = e.q0;
        if (mode == 1) start = 1;
        else if (mode == 2) start = 0;
        else start = 1'($urandom_range(0, 1));
      end
      #2;
      chk("model a_ctrl", 32'(a_ctrl), 32'(e.a));
      chk("model q_ctrl", 32'(q_ctrl), 32'(e.q));
      chk("model busy", 32'(busy), 32'(e.busy));
      chk("model done", 32'(done), 32'(e.done));
      chk("model iter", 32'(iter_count), 32'(e.iter));
      @(negedge clock);
    end
  endtask

  // Runs one operation from IDLE with a bench-side Q register feeding q0.
  task automatic run_vec(input vec_t v, input int idx);
    logic [WIDTH-1:0] qreg;
    string tag;
    tag = $sformatf("vec%0d", idx);
    qreg = '0;
    start = 1; q0 = 0;
    #2;
    chk({tag, " idle a"}, 32'(a_ctrl), 32'(2'b11));
    chk({tag, " idle busy"}, 32'(busy), 0);
    @(negedge clock);
    for (int k = 1; k <= v.len; k++) begin
      start = v.smask[k];
      q0 = qreg[0];
      #2;
      chk($sformatf("%s a[%0d]", tag, k), 32'(a_ctrl), 32'(v.seq[k-1]));
      chk($sformatf("%s done[%0d]", tag, k), 32'(done), 32'(k == v.len));
      chk($sformatf("%s busy[%0d]", tag, k), 32'(busy), 32'(k < v.len));
      if (k == v.len) chk({tag, " iter"}, 32'(iter_count), WIDTH);
      if (q_ctrl == 2'b00) qreg = v.m;
      else if (q_ctrl == 2'b10) qreg = qreg >> 1;
      @(negedge clock);
    end
    start = 0;
    #2;
    chk({tag, " post a"}, 32'(a_ctrl), 32'(2'b11));
    chk({tag, " post busy"}, 32'(busy), 0);
    chk({tag, " post iter"}, 32'(iter_count), WIDTH);
    @(negedge clock);
  endtask

  initial begin
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
    tbl[0] = '{4'b0101, 8,  {2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10,
                             2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11},
               16'h0};
    tbl[1] = '{4'b0000, 6,  {2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
                             2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11},
               16'h0};
    tbl[3] = '{4'b1011, 9,  {2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10,
                             2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11},
               16'h0};
`else
    tbl[0] = '{4'b1011, 10, {2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11,
                             2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11},
               16'h0};
    tbl[1] = '{4'b0000, 10, {2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11,
                             2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11},
               16'h0};
    tbl[3] = '{4'b0110, 10, {2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00,
                             2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11},
               16'h0};
`endif
    // start raised in INIT, ADD, SHIFT and DONE must all be ignored
    tbl[2] = '{4'b1111, 10, {2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00,
                             2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11},
               16'h040E};

    reset = 1; start = 1; q0 = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #2;
      chk("rst a_ctrl", 32'(a_ctrl), 32'(2'b01));
      chk("rst q_ctrl", 32'(q_ctrl), 32'(2'b11));
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst iter", 32'(iter_count), 0);
    end
    @(negedge clock);
    reset = 0; start = 0;
    #2;
    chk("rel a_ctrl", 32'(a_ctrl), 32'(2'b11));
    chk("rel q_ctrl", 32'(q_ctrl), 32'(2'b11));
    chk("rel busy", 32'(busy), 0);
    @(negedge clock);

    for (int i = 0; i < 4; i++) run_vec(tbl[i], i);

    iter_hold = WIDTH;
    run_model(300, 0);
    run_model(40, 1);
    run_model(30, 2);

    // reset during the third ADD aborts the operation
    start = 1; q0 = 0;
    @(negedge clock);
    start = 0;
    for (int k = 1; k < THIRD_ADD; k++) begin
      #2;
      chk("abort pre done", 32'(done), 0);
      @(negedge clock);
    end
    reset = 1;
    #2;
    chk("abort rst a", 32'(a_ctrl), 32'(2'b01));
    chk("abort rst q", 32'(q_ctrl), 32'(2'b11));
    chk("abort rst busy", 32'(busy), 0);
    @(negedge clock);
    reset = 0;
    #2;
    chk("abort idle a", 32'(a_ctrl), 32'(2'b11));
    chk("abort idle busy", 32'(busy), 0);
    chk("abort idle iter", 32'(iter_count), 0);
    @(negedge clock);
    for (int k = 0; k < 12; k++) begin
      #2;
      chk("abort no done", 32'(done), 0);
      chk("abort no busy", 32'(busy), 0);
      @(negedge clock);
    end

    iter_hold = 0;
    run_model(100, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
